// File: rtl/up_bus_arbiter.sv
// Round-robin arbiter sharing one up register bus between NUM_OF_MASTERS requesters.
// One transaction in flight at a time; every slave access is bounded by an ack timeout.
module up_bus_arbiter #(
  parameter int          NUM_OF_MASTERS = 2,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADDEAD
) (
  input  logic                         up_clk,
  input  logic                         up_rst,
  input  logic [NUM_OF_MASTERS-1:0]    m_wreq,
  input  logic [14*NUM_OF_MASTERS-1:0] m_waddr,
  input  logic [32*NUM_OF_MASTERS-1:0] m_wdata,
  input  logic [NUM_OF_MASTERS-1:0]    m_rreq,
  input  logic [14*NUM_OF_MASTERS-1:0] m_raddr,
  output logic [NUM_OF_MASTERS-1:0]    m_wack,
  output logic [NUM_OF_MASTERS-1:0]    m_rack,
  output logic [31:0]                  m_rdata,
  output logic                         m_err,
  output logic                         s_wreq,
  output logic [13:0]                  s_waddr,
  output logic [31:0]                  s_wdata,
  input  logic                         s_wack,
  output logic                         s_rreq,
  output logic [13:0]                  s_raddr,
  input  logic [31:0]                  s_rdata,
  input  logic                         s_rack,
  output logic [7:0]                   timeout_cnt,
  input  logic                         timeout_clr
);

  localparam int            PW       = (NUM_OF_MASTERS > 1) ? $clog2(NUM_OF_MASTERS) : 1;
  localparam logic [15:0]   TO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] LAST_M   = PW'(NUM_OF_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state, state_nxt;
  logic [NUM_OF_MASTERS-1:0] pending;
  logic [PW-1:0]             rr_ptr, grant;
  logic [PW-1:0]             pick, pick_lo, pick_hi;
  logic                      lo_vld, hi_vld;
  logic                      sel_wr;
  logic [13:0]               sel_waddr, sel_raddr;
  logic [31:0]               sel_wdata;
  logic                      is_wr;
  logic [15:0]               wait_cnt;
  logic                      ack_hit, to_hit;

  assign pending = m_wreq | m_rreq;
  assign ack_hit = is_wr ? s_wack : s_rack;
  assign to_hit  = (wait_cnt == TO_LIMIT);

  // Lowest pending index at/above rr_ptr wins; otherwise wrap to the lowest pending index.
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    lo_vld  = 1'b0;
    hi_vld  = 1'b0;
    for (int i = NUM_OF_MASTERS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_lo = PW'(i);
        lo_vld  = 1'b1;
      end
      if (pending[i] && (PW'(i) >= rr_ptr)) begin
        pick_hi = PW'(i);
        hi_vld  = 1'b1;
      end
    end
    pick = hi_vld ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_waddr = '0;
    sel_wdata = '0;
    sel_raddr = '0;
    for (int i = 0; i < NUM_OF_MASTERS; i++) begin
      if (PW'(i) == pick) begin
        sel_wr    = m_wreq[i];
        sel_waddr = m_waddr[i*14 +: 14];
        sel_wdata = m_wdata[i*32 +: 32];
        sel_raddr = m_raddr[i*14 +: 14];
      end
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lo_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (ack_hit || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      grant    <= '0;
      is_wr    <= 1'b0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      s_wreq   <= 1'b0;
      s_rreq   <= 1'b0;
      s_waddr  <= '0;
      s_wdata  <= '0;
      s_raddr  <= '0;
      m_wack   <= '0;
      m_rack   <= '0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
    end else begin
      s_wreq <= 1'b0;
      s_rreq <= 1'b0;
      m_wack <= '0;
      m_rack <= '0;
      m_err  <= 1'b0;
      case (state)
        IDLE: if (lo_vld) begin
          grant  <= pick;
          is_wr  <= sel_wr;
          s_wreq <= sel_wr;
          s_rreq <= !sel_wr;
          if (sel_wr) begin
            s_waddr <= sel_waddr;
            s_wdata <= sel_wdata;
          end else begin
            s_raddr <= sel_raddr;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: if (ack_hit || to_hit) begin
          // A real ack in the final timer cycle still counts as a clean completion.
          m_wack[grant] <= is_wr;
          m_rack[grant] <= !is_wr;
          m_err         <= !ack_hit;
          if (!is_wr) m_rdata <= ack_hit ? s_rdata : ERR_RDATA;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
        RESP: rr_ptr <= (grant == LAST_M) ? '0 : grant + PW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst)
      timeout_cnt <= '0;
    else if (timeout_clr)
      timeout_cnt <= '0;
    else if ((state == WAIT) && !ack_hit && to_hit && (timeout_cnt != 8'hFF))
      timeout_cnt <= timeout_cnt + 8'd1;
  end

endmodule
